trace_sequencer: RTL and testbench
==================================

# trace_sequencer

Frame-level controller for the wing-outline tracer. It takes a completed edge frame from the edge-detection stage, grants the edge BRAM to the tracer, and drives the tracer's start/done handshake. A watchdog bounds each trace, and every frame yields exactly one result record. The block sits between the edge detector (frame producer) and the wing-geometry consumer, and owns the edge-BRAM ownership select.

## Interface
- `MIN_PIXELS`, 100: minimum traced contour length for a valid outline.
- `TIMEOUT_CYCLES`, 4_000_000: watchdog limit on one trace, counted in clk cycles.
- `MAX_FAILS`, 4: consecutive failed frames that set `stuck`.
- `ARM_CYCLES`, 2: cycles `trace_start` is held low before each run.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_ready` in 1: level from the detector; the edge BRAM holds a complete frame.
- `frame_ack` out 1: one-cycle pulse that releases the frame back to the detector.
- `bram_owner` out 1: edge-BRAM mux select; 1 = tracer, 0 = detector.
- `trace_start` out 1: tracer run level; low holds the tracer in setup.
- `trace_done` in 1: tracer finished, including the clear pass.
- `trace_num_pixels` in 12: contour length from the tracer, valid while `trace_done` is high.
- `result_valid` out 1: result record available.
- `result_ready` in 1: consumer accepts the record.
- `result_pixels` out 12: latched contour length; 0 on timeout.
- `result_ok` out 1: 1 when the trace completed and `result_pixels >= MIN_PIXELS`.
- `result_timeout` out 1: the watchdog expired for this frame.
- `busy` out 1: high in every state except IDLE.
- `stuck` out 1: sticky flag for `MAX_FAILS` consecutive failed frames.
- `frame_count` out 16: frames processed; wraps at 65535→0.

## Operation
- States: IDLE, ARM, RUN, EVAL, REPORT, RELEASE.
- **IDLE**
  - `bram_owner`=0 and `trace_start`=0.
  - Leave for ARM when `frame_ready`=1 and `rearm`=1. On that transition set `bram_owner`=1 and clear `rearm`.
  - `rearm` is set whenever `frame_ready` is sampled 0. Its reset value is 1.
- **ARM**
  - Hold `trace_start`=0 for exactly `ARM_CYCLES` cycles, then go to RUN.
  - The watchdog is cleared on entry to RUN.
- **RUN**
  - `trace_start`=1 and the watchdog increments every cycle.
  - If `trace_done`=1: latch `trace_num_pixels`, then go to EVAL.
  - Otherwise, if the watchdog equals `TIMEOUT_CYCLES-1`: set `result_timeout`=1, set `result_pixels`=0, then go to EVAL.
  - `trace_done` and watchdog expiry in the same cycle: done wins.
- **EVAL** (one cycle)
  - Drop `trace_start` to 0.
  - Compute `result_ok`. The comparison is unsigned on 12 bits.
  - Update the failure counter: cleared on ok; on fail, increment saturating at `MAX_FAILS`.
  - Set `stuck` when the counter reaches `MAX_FAILS`. `stuck` clears only on the next ok result or on reset.
  - Increment `frame_count`.
  - Go to REPORT.
- **REPORT**
  - `result_valid`=1, with `result_pixels`, `result_ok` and `result_timeout` held stable.
  - On `result_valid` && `result_ready`, go to RELEASE.
  - `result_ready` already high on entry: the handshake completes in the first REPORT cycle.
- **RELEASE** (one cycle)
  - `frame_ack`=1 and `bram_owner`=0.
  - Clear `result_valid` and `result_timeout`.
  - Go to IDLE.
- `frame_ready` dropping in any state other than IDLE is ignored; it only sets `rearm`.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately.
  - The tracer is held in setup because `trace_start`=0.
  - The detector regains the BRAM.
  - The frame is not acked.

## Timing
- Reset values: `frame_ack` 0, `bram_owner` 0, `trace_start` 0, `result_valid` 0, `result_pixels` 0, `result_ok` 0, `result_timeout` 0, `busy` 0, `stuck` 0, `frame_count` 0. State is IDLE.
- All outputs are registered.
- `frame_ready` to first `trace_start`=1: 1 + `ARM_CYCLES` cycles.
- `trace_done` to `result_valid`: 2 cycles (EVAL, then REPORT).
- Accept to `frame_ack`: 1 cycle.
- `trace_start` is low for at least 1 cycle between frames and at least `ARM_CYCLES` before each run.
- The watchdog counter is 23 bits wide. `TIMEOUT_CYCLES` must be at least 2.

## Structure
- Shared package `wings_pkg` holds:
  - State enum.
  - Edge-BRAM codes: `EDGE_CAND`=3'b011, `EDGE_TRACED`=3'b111, `EDGE_KEEP`=3'b001.
  - `WIDTH`=640, `HEIGHT`=480.
  - BRAM address width 19.
- One natural sub-module: `cycle_timer`, a clearable enable counter with a terminal-count flag, used as the watchdog.
- The tracer and BRAM mux are instantiated by the parent, not inside this block.

## Test plan
- Good trace:
  - Stimulus: `frame_ready`=1; `trace_done` with 250 pixels, 100 cycles after start.
  - Required: `result_valid` with `result_pixels`=250, `result_ok`=1, `result_timeout`=0.
  - Required: `frame_ack` 1 cycle after `result_ready`; `frame_count`=1.
- Short trace:
  - Stimulus: done with 99 pixels, `MIN_PIXELS`=100.
  - Required: `result_ok`=0, failure counter 1, `stuck`=0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=50, `trace_done` never asserted.
  - Required: `trace_start` falls exactly 50 cycles after rising.
  - Required: `result_timeout`=1, `result_pixels`=0.
- Stuck and recovery:
  - Stimulus: 4 consecutive failed frames, then one 300-pixel frame.
  - Required: `stuck`=1 after the 4th EVAL; `stuck`=0 after the 5th EVAL.
- Re-arm and backpressure:
  - Stimulus: hold `frame_ready`=1 across `frame_ack`; hold `result_ready`=0 for 20 cycles.
  - Required: no new frame starts until `frame_ready` is sampled low.
  - Required: the result stays stable during the 20 stalled cycles.
- Reset during RUN:
  - Stimulus: assert `rst_n`=0 while `trace_start`=1.
  - Required: `trace_start`=0, `bram_owner`=0, `frame_ack` never pulses, state returns to IDLE.

Source files
------------

// File: rtl/wings_pkg.sv
// Shared types and constants for the wing-outline pipeline.
package wings_pkg;

    localparam int unsigned WIDTH       = 640;
    localparam int unsigned HEIGHT      = 480;
    localparam int unsigned BRAM_ADDR_W = 19;
    localparam int unsigned PIX_W       = 12;
    localparam int unsigned WD_W        = 23;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [2:0] EDGE_CAND   = 3'b011;
    localparam logic [2:0] EDGE_TRACED = 3'b111;
    localparam logic [2:0] EDGE_KEEP   = 3'b001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        EVAL    = 3'd3,
        REPORT  = 3'd4,
        RELEASE = 3'd5
    } seq_state_t;

    // One result record handed to the geometry consumer per frame.
    typedef struct packed {
        logic [PIX_W-1:0] pixels;
        logic             ok;
        logic             timeout;
    } result_t;

endpackage

// File: rtl/trace_sequencer_cycle_timer.sv
// Clearable enable counter with a terminal-count flag; serves as the trace watchdog.
module cycle_timer
    import wings_pkg::*;
#(
    parameter int unsigned CNT_W = WD_W,
    parameter int unsigned LIMIT = 4_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/trace_sequencer.sv
// Frame-level controller: grants the edge BRAM to the tracer, runs it under a
// watchdog and emits exactly one result record per frame.
module trace_sequencer
    import wings_pkg::*;
#(
    parameter int unsigned MIN_PIXELS     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000,
    parameter int unsigned MAX_FAILS      = 4,
    parameter int unsigned ARM_CYCLES     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_ready,
    output logic                   frame_ack,
    output logic                   bram_owner,
    output logic                   trace_start,
    input  logic                   trace_done,
    input  logic [PIX_W-1:0]       trace_num_pixels,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [PIX_W-1:0]       result_pixels,
    output logic                   result_ok,
    output logic                   result_timeout,
    output logic                   busy,
    output logic                   stuck,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned ARM_W  = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    seq_state_t             state, state_next;
    logic [ARM_W-1:0]       arm_cnt, arm_cnt_d;
    logic [FAIL_W-1:0]      fail_cnt, fail_cnt_d;
    logic                   rearm, rearm_d;
    result_t                res_q, res_d;
    logic                   frame_ack_d, bram_owner_d, trace_start_d;
    logic                   result_valid_d, stuck_d, busy_d;
    logic [FRAME_CNT_W-1:0] frame_count_d;
    logic                   wd_clr_c, wd_tc_c;

    cycle_timer #(
        .CNT_W (WD_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr_c),
        .en    (state == RUN),
        .tc_c  (wd_tc_c)
    );

    // State and every output are registered from their next values here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            arm_cnt      <= '0;
            fail_cnt     <= '0;
            rearm        <= 1'b1;
            res_q        <= '0;
            frame_ack    <= 1'b0;
            bram_owner   <= 1'b0;
            trace_start  <= 1'b0;
            result_valid <= 1'b0;
            stuck        <= 1'b0;
            busy         <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_next;
            arm_cnt      <= arm_cnt_d;
            fail_cnt     <= fail_cnt_d;
            rearm        <= rearm_d;
            res_q        <= res_d;
            frame_ack    <= frame_ack_d;
            bram_owner   <= bram_owner_d;
            trace_start  <= trace_start_d;
            result_valid <= result_valid_d;
            stuck        <= stuck_d;
            busy         <= busy_d;
            frame_count  <= frame_count_d;
        end
    end

    always_comb begin
        state_next     = state;
        arm_cnt_d      = arm_cnt;
        fail_cnt_d     = fail_cnt;
        rearm_d        = rearm | ~frame_ready;
        res_d          = res_q;
        frame_ack_d    = 1'b0;
        bram_owner_d   = bram_owner;
        trace_start_d  = trace_start;
        result_valid_d = result_valid;
        stuck_d        = stuck;
        frame_count_d  = frame_count;
        wd_clr_c       = 1'b0;

        case (state)
            IDLE: begin
                bram_owner_d  = 1'b0;
                trace_start_d = 1'b0;
                // A frame held high across the ack must be seen low before it starts again.
                if (frame_ready && rearm) begin
                    state_next   = ARM;
                    bram_owner_d = 1'b1;
                    rearm_d      = 1'b0;
                    arm_cnt_d    = '0;
                end
            end
            ARM: begin
                trace_start_d = 1'b0;
                if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
                    state_next    = RUN;
                    trace_start_d = 1'b1;
                    wd_clr_c      = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt + ARM_W'(1);
                end
            end
            RUN: begin
                if (trace_done) begin
                    res_d.pixels  = trace_num_pixels;
                    res_d.timeout = 1'b0;
                    trace_start_d = 1'b0;
                    state_next    = EVAL;
                end else if (wd_tc_c) begin
                    res_d.pixels  = '0;
                    res_d.timeout = 1'b1;
                    trace_start_d = 1'b0;
                    state_next    = EVAL;
                end
            end
            EVAL: begin
                res_d.ok = ~res_q.timeout && (res_q.pixels >= PIX_W'(MIN_PIXELS));
                if (res_d.ok) begin
                    fail_cnt_d = '0;
                    stuck_d    = 1'b0;
                end else begin
                    if (fail_cnt != FAIL_W'(MAX_FAILS)) begin
                        fail_cnt_d = fail_cnt + FAIL_W'(1);
                    end
                    if (fail_cnt_d == FAIL_W'(MAX_FAILS)) begin
                        stuck_d = 1'b1;
                    end
                end
                frame_count_d  = frame_count + FRAME_CNT_W'(1);
                result_valid_d = 1'b1;
                state_next     = REPORT;
            end
            REPORT: begin
                if (result_valid && result_ready) begin
                    result_valid_d = 1'b0;
                    res_d.timeout  = 1'b0;
                    frame_ack_d    = 1'b1;
                    bram_owner_d   = 1'b0;
                    state_next     = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_d = (state_next != IDLE);
    end

    assign result_pixels  = res_q.pixels;
    assign result_ok      = res_q.ok;
    assign result_timeout = res_q.timeout;

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer: main DUT plus a short-watchdog instance for timeout.
module tb_trace_sequencer;
    import wings_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        frame_ready, trace_done, result_ready;
    logic [11:0] trace_num_pixels;
    logic        frame_ack, bram_owner, trace_start, result_valid;
    logic [11:0] result_pixels;
    logic        result_ok, result_timeout, busy, stuck;
    logic [15:0] frame_count;

    logic        b_frame_ready, b_result_ready;
    logic        b_frame_ack, b_bram_owner, b_trace_start, b_result_valid;
    logic [11:0] b_result_pixels;
    logic        b_result_ok, b_result_timeout, b_busy, b_stuck;
    logic [15:0] b_frame_count;

    int n_cmp = 0;
    int n_err = 0;

    trace_sequencer #(
        .MIN_PIXELS(100), .TIMEOUT_CYCLES(1000), .MAX_FAILS(4), .ARM_CYCLES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .frame_ack(frame_ack),
        .bram_owner(bram_owner), .trace_start(trace_start), .trace_done(trace_done),
        .trace_num_pixels(trace_num_pixels), .result_valid(result_valid),
        .result_ready(result_ready), .result_pixels(result_pixels), .result_ok(result_ok),
        .result_timeout(result_timeout), .busy(busy), .stuck(stuck), .frame_count(frame_count)
    );

    trace_sequencer #(
        .MIN_PIXELS(100), .TIMEOUT_CYCLES(50), .MAX_FAILS(4), .ARM_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_ready(b_frame_ready), .frame_ack(b_frame_ack),
        .bram_owner(b_bram_owner), .trace_start(b_trace_start), .trace_done(1'b0),
        .trace_num_pixels(12'd0), .result_valid(b_result_valid),
        .result_ready(b_result_ready), .result_pixels(b_result_pixels), .result_ok(b_result_ok),
        .result_timeout(b_result_timeout), .busy(b_busy), .stuck(b_stuck), .frame_count(b_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_a_start(output int cyc);
        cyc = 0;
        while (!trace_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("a_start_seen", 32'(trace_start), 32'd1);
    endtask

    // Runs one frame on dut_a up to the REPORT state; done is sampled dly cycles after start.
    task automatic a_frame(input logic [11:0] pix, input int dly, input bit keep_ready);
        int cyc;
        frame_ready = 1'b1;
        wait_a_start(cyc);
        repeat (dly - 1) @(negedge clk);
        trace_done       = 1'b1;
        trace_num_pixels = pix;
        @(negedge clk);
        trace_done = 1'b0;
        if (!keep_ready) frame_ready = 1'b0;
        chk("eval_start_low", 32'(trace_start), 32'd0);
        chk("eval_valid_low", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("report_valid", 32'(result_valid), 32'd1);
        chk("report_pixels", 32'(result_pixels), 32'(pix));
    endtask

    task automatic a_accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("ack_pulse", 32'(frame_ack), 32'd1);
        chk("ack_owner", 32'(bram_owner), 32'd0);
        chk("ack_valid_clr", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("idle_ack_low", 32'(frame_ack), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1;
        frame_ready = 0; trace_done = 0; result_ready = 0; trace_num_pixels = '0;
        b_frame_ready = 0; b_result_ready = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ack", 32'(frame_ack), 0);
        chk("rst_owner", 32'(bram_owner), 0);
        chk("rst_start", 32'(trace_start), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_pixels", 32'(result_pixels), 0);
        chk("rst_ok", 32'(result_ok), 0);
        chk("rst_timeout", 32'(result_timeout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stuck", 32'(stuck), 0);
        chk("rst_count", 32'(frame_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good trace, frame_ready held high across the ack
        frame_ready = 1'b1;
        @(negedge clk);
        chk("arm_owner", 32'(bram_owner), 1);
        chk("arm_busy", 32'(busy), 1);
        chk("arm_start_low", 32'(trace_start), 0);
        wait_a_start(cyc);
        chk("start_latency", 32'(cyc), 32'd2);
        repeat (99) @(negedge clk);
        trace_done = 1'b1; trace_num_pixels = 12'd250;
        @(negedge clk);
        trace_done = 1'b0;
        chk("good_eval_start_low", 32'(trace_start), 0);
        @(negedge clk);
        chk("good_valid", 32'(result_valid), 1);
        chk("good_pixels", 32'(result_pixels), 250);
        chk("good_ok", 32'(result_ok), 1);
        chk("good_timeout", 32'(result_timeout), 0);
        chk("good_count", 32'(frame_count), 1);
        a_accept();
        repeat (5) @(negedge clk);
        chk("rearm_hold_busy", 32'(busy), 0);
        chk("rearm_hold_owner", 32'(bram_owner), 0);
        frame_ready = 1'b0;
        @(negedge clk);

        // Short trace (99 < 100)
        a_frame(12'd99, 10, 1'b0);
        chk("short_ok", 32'(result_ok), 0);
        chk("short_fails", 32'(dut_a.fail_cnt), 1);
        chk("short_stuck", 32'(stuck), 0);
        chk("short_count", 32'(frame_count), 2);
        a_accept();

        // Failures 2..4 then saturation
        a_frame(12'd0, 3, 1'b0);
        chk("f2_stuck", 32'(stuck), 0);
        a_accept();
        a_frame(12'd50, 3, 1'b0);
        chk("f3_fails", 32'(dut_a.fail_cnt), 3);
        chk("f3_stuck", 32'(stuck), 0);
        a_accept();
        a_frame(12'd99, 3, 1'b0);
        chk("f4_stuck", 32'(stuck), 1);
        chk("f4_fails", 32'(dut_a.fail_cnt), 4);
        a_accept();
        a_frame(12'd99, 3, 1'b0);
        chk("f5_sat_fails", 32'(dut_a.fail_cnt), 4);
        chk("f5_stuck", 32'(stuck), 1);
        a_accept();

        // Recovery
        a_frame(12'd300, 3, 1'b0);
        chk("rec_ok", 32'(result_ok), 1);
        chk("rec_stuck", 32'(stuck), 0);
        chk("rec_fails", 32'(dut_a.fail_cnt), 0);
        chk("rec_count", 32'(frame_count), 7);
        a_accept();

        // Exact threshold and full-scale count
        a_frame(12'd100, 1, 1'b0);
        chk("edge100_ok", 32'(result_ok), 1);
        a_accept();
        a_frame(12'd4095, 2, 1'b0);
        chk("edge4095_ok", 32'(result_ok), 1);
        a_accept();

        // Backpressure: record held stable for 20 stalled cycles
        a_frame(12'd250, 5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(result_valid), 1);
            chk("stall_pixels", 32'(result_pixels), 250);
            chk("stall_ok", 32'(result_ok), 1);
            chk("stall_ack", 32'(frame_ack), 0);
        end
        chk("stall_count", 32'(frame_count), 10);
        a_accept();

        // Watchdog timeout on the short-limit instance
        b_frame_ready = 1'b1;
        cyc = 0;
        while (!b_trace_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b_start_seen", 32'(b_trace_start), 1);
        cyc = 0;
        while (b_trace_start && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        b_frame_ready = 1'b0;
        chk("to_start_width", 32'(cyc), 50);
        @(negedge clk);
        chk("to_valid", 32'(b_result_valid), 1);
        chk("to_timeout", 32'(b_result_timeout), 1);
        chk("to_pixels", 32'(b_result_pixels), 0);
        chk("to_ok", 32'(b_result_ok), 0);
        b_result_ready = 1'b1;
        @(negedge clk);
        b_result_ready = 1'b0;
        chk("to_ack", 32'(b_frame_ack), 1);
        chk("to_timeout_clr", 32'(b_result_timeout), 0);

        // Reset asserted during RUN
        frame_ready = 1'b1;
        wait_a_start(cyc);
        repeat (5) @(negedge clk);
        chk("pre_rst_start", 32'(trace_start), 1);
        rst_n = 1'b0;
        frame_ready = 1'b0;
        #1;
        chk("rst_run_start", 32'(trace_start), 0);
        chk("rst_run_owner", 32'(bram_owner), 0);
        chk("rst_run_busy", 32'(busy), 0);
        chk("rst_run_state", 32'(dut_a.state), 32'(IDLE));
        chk("rst_run_count", 32'(frame_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 32'(frame_ack), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
